// File: rtl/speccfa_pkg.sv
// Shared encodings and widths for the speculation block-match sequencer.
package speccfa_pkg;

  localparam int unsigned ID_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned LOG_W      = 16;
  localparam int unsigned IDX_W      = 16;
  localparam int unsigned KIND_W     = 2;
  localparam int unsigned ST_W       = 2;

  localparam logic [KIND_W-1:0] KIND_PASS  = 2'd0;
  localparam logic [KIND_W-1:0] KIND_HIT   = 2'd1;
  localparam logic [KIND_W-1:0] KIND_ABORT = 2'd2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SEARCH = 2'd1;
  localparam logic [ST_W-1:0] ST_TRACK  = 2'd2;

  // One control-flow edge as carried by the log and stored in block memory.
  typedef struct packed {
    logic [LOG_W-1:0] src;
    logic [LOG_W-1:0] dest;
  } cf_entry_t;

endpackage

// File: rtl/speccfa_entry_cmp.sv
// Combinational {src,dest} equality between a log entry and a block entry.
module speccfa_entry_cmp
  import speccfa_pkg::*;
(
  input  cf_entry_t a_i,
  input  cf_entry_t b_i,
  output logic      match_o
);

  assign match_o = (a_i == b_i);

endmodule

// File: rtl/speccfa_spec_ctrl.sv
// Speculation block-match sequencer: walks block memory per log entry and
// reports PASS, HIT or ABORT one cycle after each decision.
module speccfa_spec_ctrl
  import speccfa_pkg::*;
#(
  parameter int unsigned ID_W   = ID_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              spec_en,
  input  logic [IDX_W-1:0]  total_blocks,
  input  logic              log_valid,
  input  logic [LOG_W-1:0]  log_src,
  input  logic [LOG_W-1:0]  log_dest,
  output logic              log_ready,
  output logic [ADDR_W-1:0] block_base,
  output logic [ADDR_W-1:0] block_ptr,
  input  logic [LOG_W-1:0]  block_entry_src,
  input  logic [LOG_W-1:0]  block_entry_dest,
  input  logic [ID_W-1:0]   block_len,
  input  logic [ID_W-1:0]   block_id,
  output logic              out_valid,
  output logic [KIND_W-1:0] out_kind,
  output logic [ID_W-1:0]   out_id,
  output logic [ID_W-1:0]   out_len,
  output logic              busy
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   len_q, len_d;
  logic              out_valid_q, out_valid_d;
  logic [KIND_W-1:0] out_kind_q, out_kind_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   out_len_q, out_len_d;
  logic              busy_q;
  logic              ready_c;
  logic              match_c;
  logic [IDX_W-1:0]  idx_inc;
  logic [ID_W-1:0]   ptr_inc;
  cf_entry_t         log_entry;
  cf_entry_t         blk_entry;

  assign log_entry = {log_src, log_dest};
  assign blk_entry = {block_entry_src, block_entry_dest};
  assign idx_inc   = idx_q + IDX_W'(1);
  assign ptr_inc   = ptr_q + ID_W'(1);

  speccfa_entry_cmp u_cmp (
    .a_i     (log_entry),
    .b_i     (blk_entry),
    .match_o (match_c)
  );

  // Next-state and result decision for the current cycle.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    id_d        = id_q;
    len_d       = len_q;
    out_valid_d = 1'b0;
    out_kind_d  = out_kind_q;
    out_id_d    = out_id_q;
    out_len_d   = out_len_q;
    ready_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (log_valid) begin
          if (spec_en && (total_blocks != '0)) begin
            state_d = ST_SEARCH;
          end else begin
            ready_c     = 1'b1;
            out_valid_d = 1'b1;
            out_kind_d  = KIND_PASS;
            out_id_d    = '0;
            out_len_d   = '0;
          end
        end
      end

      ST_SEARCH: begin
        // A zero-length header is malformed and ends the walk before any match.
        if (block_len == '0) begin
          ready_c     = 1'b1;
          out_valid_d = 1'b1;
          out_kind_d  = KIND_PASS;
          out_id_d    = '0;
          out_len_d   = '0;
          state_d     = ST_IDLE;
        end else if (match_c) begin
          ready_c = 1'b1;
          if (block_len == ID_W'(1)) begin
            out_valid_d = 1'b1;
            out_kind_d  = KIND_HIT;
            out_id_d    = block_id;
            out_len_d   = block_len;
            state_d     = ST_IDLE;
          end else begin
            id_d    = block_id;
            len_d   = block_len;
            ptr_d   = ID_W'(1);
            state_d = ST_TRACK;
          end
        end else if (idx_inc == total_blocks) begin
          ready_c     = 1'b1;
          out_valid_d = 1'b1;
          out_kind_d  = KIND_PASS;
          out_id_d    = '0;
          out_len_d   = '0;
          state_d     = ST_IDLE;
        end else begin
          idx_d  = idx_inc;
          base_d = base_q + ADDR_W'(block_len);
        end
      end

      ST_TRACK: begin
        if (!spec_en) begin
          out_valid_d = 1'b1;
          out_kind_d  = KIND_ABORT;
          out_id_d    = '0;
          out_len_d   = ptr_q;
          state_d     = ST_IDLE;
        end else if (log_valid) begin
          if (match_c) begin
            ready_c = 1'b1;
            if (ptr_inc == len_q) begin
              out_valid_d = 1'b1;
              out_kind_d  = KIND_HIT;
              out_id_d    = id_q;
              out_len_d   = len_q;
              state_d     = ST_IDLE;
            end else begin
              ptr_d = ptr_inc;
            end
          end else begin
            // Entry stays pending and is re-searched from block 0.
            out_valid_d = 1'b1;
            out_kind_d  = KIND_ABORT;
            out_id_d    = '0;
            out_len_d   = ptr_q;
            state_d     = ST_SEARCH;
            base_d      = '0;
            ptr_d       = '0;
            idx_d       = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      base_d = '0;
      ptr_d  = '0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      id_q        <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_kind_q  <= '0;
      out_id_q    <= '0;
      out_len_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      id_q        <= id_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_id_q    <= out_id_d;
      out_len_q   <= out_len_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign log_ready  = ready_c;
  assign block_base = base_q;
  assign block_ptr  = ADDR_W'(ptr_q);
  assign out_valid  = out_valid_q;
  assign out_kind   = out_kind_q;
  assign out_id     = out_id_q;
  assign out_len    = out_len_q;
  assign busy       = busy_q;

endmodule
